// File: rtl/cpuid_query_if.sv
// CSR-side query/response bundle for cpuid_query_fsm.
// The master modport is the CSR unit; the slave modport is the query FSM.
interface cpuid_query_if;
  // Both channels use valid/ready. A transfer happens on a clock edge where valid and ready are both high.
  // A producer holds its payload stable while valid is high. Ready never depends on valid.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_leaf;
  logic [31:0] req_subleaf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data0;
  logic [63:0] rsp_data1;
  logic [63:0] rsp_data2;
  logic [63:0] rsp_data3;
  logic        rsp_zero;
  logic        rsp_cached;

  modport master (
    output req_valid, req_leaf, req_subleaf, rsp_ready,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3,
           rsp_zero, rsp_cached
  );

  modport slave (
    input  req_valid, req_leaf, req_subleaf, rsp_ready,
    output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3,
           rsp_zero, rsp_cached
  );
endinterface

// File: rtl/cpuid_query_fsm.sv
// Requester for the CPUID CSR window: drives leaf/subleaf, waits SETTLE_CYCLES, captures four lanes.
// Optional single-entry result cache is built in when CPUID_QUERY_CACHE_EN is defined.
module cpuid_query_fsm #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  cpuid_query_if.slave      csr,
  output logic [31:0]       cpuid_leaf_o,
  output logic [31:0]       cpuid_subleaf_o,
  input  logic [63:0]       cpuid_data0_i,
  input  logic [63:0]       cpuid_data1_i,
  input  logic [63:0]       cpuid_data2_i,
  input  logic [63:0]       cpuid_data3_i,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("cpuid_query_fsm: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] leaf_q, leaf_d, sub_q, sub_d;
  logic [63:0] d0_q, d1_q, d2_q, d3_q, d0_d, d1_d, d2_d, d3_d;
  logic        zero_q, zero_d, cached_q, cached_d;
  logic        accept, capture, hit;
  logic [63:0] hit_d0, hit_d1, hit_d2, hit_d3;

`ifdef CPUID_QUERY_CACHE_EN
  logic        c_vld_q;
  logic [31:0] c_leaf_q, c_sub_q;
  logic [63:0] c_d0_q, c_d1_q, c_d2_q, c_d3_q;

  // Every responder capture refills the cache, keyed by the query that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld_q  <= 1'b0;
      c_leaf_q <= '0;
      c_sub_q  <= '0;
      c_d0_q   <= '0;
      c_d1_q   <= '0;
      c_d2_q   <= '0;
      c_d3_q   <= '0;
    end else if (capture) begin
      c_vld_q  <= 1'b1;
      c_leaf_q <= leaf_q;
      c_sub_q  <= sub_q;
      c_d0_q   <= cpuid_data0_i;
      c_d1_q   <= cpuid_data1_i;
      c_d2_q   <= cpuid_data2_i;
      c_d3_q   <= cpuid_data3_i;
    end
  end

  assign hit    = c_vld_q && (csr.req_leaf == c_leaf_q) && (csr.req_subleaf == c_sub_q);
  assign hit_d0 = c_d0_q;
  assign hit_d1 = c_d1_q;
  assign hit_d2 = c_d2_q;
  assign hit_d3 = c_d3_q;
`else
  assign hit    = 1'b0;
  assign hit_d0 = '0;
  assign hit_d1 = '0;
  assign hit_d2 = '0;
  assign hit_d3 = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      leaf_q   <= '0;
      sub_q    <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
      zero_q   <= 1'b0;
      cached_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      leaf_q   <= leaf_d;
      sub_q    <= sub_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      zero_q   <= zero_d;
      cached_q <= cached_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = hit ? RESP : SETTLE;
      SETTLE:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (csr.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr.req_ready = (state_q == IDLE) & ~rst;
    csr.rsp_valid = (state_q == RESP);
    busy_o        = (state_q != IDLE);
    state_o       = state_q;
    accept        = csr.req_valid & csr.req_ready;
    capture       = (state_q == SETTLE) && (cnt_q == 4'd0);
  end

  // Responder lanes are only looked at in the last SETTLE cycle; otherwise the result regs hold.
  always_comb begin
    cnt_d    = cnt_q;
    leaf_d   = leaf_q;
    sub_d    = sub_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    zero_d   = zero_q;
    cached_d = cached_q;
    if (accept) begin
      leaf_d = csr.req_leaf;
      sub_d  = csr.req_subleaf;
      cnt_d  = CNT_LOAD;
      if (hit) begin
        d0_d     = hit_d0;
        d1_d     = hit_d1;
        d2_d     = hit_d2;
        d3_d     = hit_d3;
        zero_d   = ~|{hit_d0, hit_d1, hit_d2, hit_d3};
        cached_d = 1'b1;
      end
    end else if (capture) begin
      d0_d     = cpuid_data0_i;
      d1_d     = cpuid_data1_i;
      d2_d     = cpuid_data2_i;
      d3_d     = cpuid_data3_i;
      zero_d   = ~|{cpuid_data0_i, cpuid_data1_i, cpuid_data2_i, cpuid_data3_i};
      cached_d = 1'b0;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign cpuid_leaf_o    = leaf_q;
  assign cpuid_subleaf_o = sub_q;
  assign csr.rsp_data0   = d0_q;
  assign csr.rsp_data1   = d1_q;
  assign csr.rsp_data2   = d2_q;
  assign csr.rsp_data3   = d3_q;
  assign csr.rsp_zero    = zero_q;
  assign csr.rsp_cached  = cached_q;

endmodule
